// File: rtl/ttl_bus_capture.sv
// ttl_bus_capture: receive side of an octal tristate bus driver.
// Synchronizes an asynchronous 8-bit bus and its active-low strobe, waits SETTLE
// clocks after the strobe falls, captures one byte per strobe into a small FIFO
// and presents the FIFO head on a valid/ready port.
//
// Handshake: a byte is transferred on every rising clk edge where
// out_valid=1 and out_ready=1; out_data is stable while out_valid=1 and
// out_ready=0, and out_valid never drops without a transfer (except on reset).
module ttl_bus_capture #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         bus_d,
    input  logic                     strobe_n,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t            state;
    logic [SW-1:0]     settle_cnt;

    logic [WIDTH-1:0]  bus_m, bus_s;
    logic              stb_m, stb_s, stb_prev;
    // live[i] marks that stage i of the strobe pipeline holds a real sample
    // rather than its reset value, so a strobe held low across reset is not
    // mistaken for a falling edge.
    logic [2:0]        live;
    logic              fe;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              cap, push, pop, drop;

    assign fe        = live[2] & ~stb_s & stb_prev;
    assign cap       = (state == ST_SETTLE) && !stb_s && (settle_cnt == SW'(SETTLE));
    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = cap & (!full | pop);
    assign drop      = cap & full & !pop;
    assign out_data  = mem[rd_ptr];

    // Two-flop synchronizers for bus and strobe, plus strobe edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_m    <= '0;
            bus_s    <= '0;
            stb_m    <= 1'b1;
            stb_s    <= 1'b1;
            stb_prev <= 1'b1;
            live     <= '0;
        end else begin
            bus_m    <= bus_d;
            bus_s    <= bus_m;
            stb_m    <= strobe_n;
            stb_s    <= stb_m;
            stb_prev <= stb_s;
            live     <= {live[1:0], 1'b1};
        end
    end

    // Capture FSM: one sample per strobe, taken SETTLE clocks after the falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fe) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (stb_s) begin
                        state <= ST_IDLE;
                    end else if (settle_cnt == SW'(SETTLE)) begin
                        state <= ST_HOLD;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_HOLD: begin
                    if (stb_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when empty after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= bus_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the same cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
